// File: rtl/light_pkg.sv
// Shared encodings for the demand-driven intersection light arbiter:
// simulator light codes, approach directions, FSM states and sensor bit positions.
package light_pkg;

  typedef enum logic [2:0] {
    L_STOP  = 3'b000,
    L_FWD   = 3'b001,
    L_LEFT  = 3'b010,
    L_RIGHT = 3'b011,
    L_GO    = 3'b100
  } light_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GREEN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int SENSOR_N = 6;
  localparam int SENSOR_S = 4;
  localparam int SENSOR_E = 5;
  localparam int SENSOR_W = 7;

  // Light for approach d given whether a grant is active and who holds it.
  function automatic logic [2:0] light_for(logic grant, dir_e holder, dir_e d);
    return (grant && (holder == d)) ? L_GO : L_STOP;
  endfunction

endpackage

// File: rtl/light_arbiter_rr_pick4.sv
// Round-robin picker: first set request strictly after `last`, wrapping
// around so `last` itself is considered only after the other three.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] next
);

  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    next  = last;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        next  = idx;
      end
    end
  end

endmodule

// File: rtl/light_arbiter.sv
// Demand-driven four-way light arbiter: one Go at a time, round-robin between
// waiting approaches, with min/max green and an all-Stop clearance interval.
module light_arbiter
  import light_pkg::*;
#(
  parameter int MIN_GREEN    = 16,
  parameter int MAX_GREEN    = 64,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor_light,
  input  logic [29:0] general_sensors,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW,
  output logic [29:0] debug_port
);

  localparam logic [7:0] MIN_LAST   = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST   = 8'(MAX_GREEN - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  dir_e       last_q, last_d;
  logic [3:0] req_q, req_d;
  logic       pick_found;
  logic [1:0] pick_dir;
  logic       gap_out, max_out, grant_d;
  logic [3:0] others;

  logic unused_inputs;
  assign unused_inputs = ^{general_sensors, sensor_light[3:0]};

  assign req_d = {sensor_light[SENSOR_W], sensor_light[SENSOR_S],
                  sensor_light[SENSOR_E], sensor_light[SENSOR_N]};

  rr_pick4 u_pick (
    .req   (req_q),
    .last  (last_q),
    .found (pick_found),
    .next  (pick_dir)
  );

  assign others  = req_q & ~(4'b0001 << last_q);
  assign gap_out = (timer_q >= MIN_LAST) && !req_q[last_q];
  assign max_out = (timer_q >= MAX_LAST) && (others != 4'b0000);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d  = last_q;
    case (state_q)
      ST_CLEAR: begin
        if (timer_q == CLEAR_LAST) begin
          if (pick_found) begin
            state_d = ST_GREEN;
            last_d  = dir_e'(pick_dir);
            timer_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GREEN;
          last_d  = dir_e'(pick_dir);
          timer_d = 8'd0;
        end
      end
      ST_GREEN: begin
        if (gap_out || max_out) begin
          state_d = ST_CLEAR;
          timer_d = 8'd0;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        timer_d = 8'd0;
      end
    endcase
  end

  assign grant_d = (state_d == ST_GREEN);

  // Lights are registered from the next-state values so they change on the
  // same edge as the state they reflect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      timer_q <= 8'd0;
      last_q  <= DIR_W;
      req_q   <= 4'b0000;
      outN    <= L_STOP;
      outS    <= L_STOP;
      outE    <= L_STOP;
      outW    <= L_STOP;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      req_q   <= req_d;
      outN    <= light_for(grant_d, last_d, DIR_N);
      outS    <= light_for(grant_d, last_d, DIR_S);
      outE    <= light_for(grant_d, last_d, DIR_E);
      outW    <= light_for(grant_d, last_d, DIR_W);
    end
  end

  assign debug_port = {14'd0, req_q, state_q, last_q, timer_q};

endmodule

// File: tb/tb_light_arbiter.sv
// Scoreboard bench for light_arbiter: directed scenarios push timed expectations,
// a negedge monitor pops and compares them and checks the one-Go/clearance invariant.
module tb_light_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sensor = 8'h00;
  logic [29:0] gen = 30'd0;
  logic [2:0]  outN, outS, outE, outW;
  logic [29:0] debug_port;

  light_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .sensor_light    (sensor),
    .general_sensors (gen),
    .outN            (outN),
    .outS            (outS),
    .outE            (outE),
    .outW            (outW),
    .debug_port      (debug_port)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] ALL_STOP = 12'h000;
  localparam logic [11:0] GO_N     = 12'h004;
  localparam logic [11:0] GO_E     = 12'h020;
  localparam logic [11:0] GO_S     = 12'h100;
  localparam logic [11:0] GO_W     = 12'h800;

  localparam int K_OUTS  = 0;
  localparam int K_STATE = 1;
  localparam int K_TIMER = 2;
  localparam int K_LAST  = 3;
  localparam int K_REQ   = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic inv_en = 1'b0;
  logic drain_fail = 1'b0;
  logic drain_seen = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void expect_at(int c, int k, logic [11:0] v, string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] s, input int n);
    rst = 1'b0;
    sensor = s;
    for (int i = 1; i <= n; i++) begin
      expect_at(cyc + i, K_OUTS,  ALL_STOP, "rst_outs");
      expect_at(cyc + i, K_STATE, 12'd2,    "rst_state");
      expect_at(cyc + i, K_TIMER, 12'd0,    "rst_timer");
      expect_at(cyc + i, K_LAST,  12'd3,    "rst_last");
      expect_at(cyc + i, K_REQ,   12'd0,    "rst_req");
    end
    step(n);
  endtask

  task automatic release_rst(input logic [7:0] s, output int rel);
    rst = 1'b1;
    sensor = s;
    rel = cyc;
  endtask

  // Monitor state
  logic [11:0] outs_now;
  logic [11:0] act;
  logic        inv_prev = 1'b0;
  logic        had_grant, prev_go, idle_seen;
  int          run, ngo;
  logic [1:0]  cur_dir, prev_dir;

  always @(negedge clk) begin
    outs_now = {outW, outS, outE, outN};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        checks++; fails++;
        $display("FAIL %s: expectation for cycle %0d was never compared (now %0d)", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_OUTS:  act = outs_now;
          K_STATE: act = {10'd0, debug_port[11:10]};
          K_TIMER: act = {4'd0, debug_port[7:0]};
          K_LAST:  act = {10'd0, debug_port[9:8]};
          default: act = {8'd0, debug_port[15:12]};
        endcase
        checks++;
        if (act !== sb[i].val) begin
          fails++;
          $display("FAIL %s @cycle %0d: got %h, expected %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end

    if (inv_en) begin
      if (!inv_prev) begin
        had_grant = 1'b0; prev_go = 1'b0; idle_seen = 1'b0; run = 0; prev_dir = 2'd0;
      end
      ngo = int'(outN == 3'b100) + int'(outE == 3'b100) + int'(outS == 3'b100) + int'(outW == 3'b100);
      checks++;
      if (ngo > 1) begin
        fails++;
        $display("FAIL one_go @cycle %0d: got %0d Go outputs, expected at most 1", cyc, ngo);
      end
      if (ngo == 1) begin
        cur_dir = (outN == 3'b100) ? 2'd0 : (outE == 3'b100) ? 2'd1 : (outS == 3'b100) ? 2'd2 : 2'd3;
        if (!prev_go && had_grant) begin
          checks++;
          if (!(run == 4 || (idle_seen && run > 4))) begin
            fails++;
            $display("FAIL clear_gap @cycle %0d: got %0d all-Stop edges (idle=%0d), expected 4", cyc, run, idle_seen);
          end
        end
        if (prev_go) begin
          checks++;
          if (cur_dir != prev_dir) begin
            fails++;
            $display("FAIL grant_switch @cycle %0d: got dir %0d, expected %0d (no Stop between)", cyc, cur_dir, prev_dir);
          end
        end
        had_grant = 1'b1; run = 0; idle_seen = 1'b0; prev_dir = cur_dir;
      end else begin
        run++;
        if (debug_port[11:10] == 2'd0) idle_seen = 1'b1;
      end
      prev_go = (ngo != 0);
    end
    inv_prev = inv_en;

    if (drain_fail && !drain_seen) begin
      drain_seen = 1'b1;
      checks++; fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
  end

  int rel;

  initial begin
    // Reset with every sensor active; N must win first, 4 edges after release.
    apply_reset(8'hFF, 2);
    release_rst(8'hFF, rel);
    for (int k = 1; k <= 3; k++) expect_at(rel + k, K_OUTS, ALL_STOP, "rst_no_early_go");
    expect_at(rel + 4, K_OUTS, GO_N, "rst_first_go_n");
    step(6);

    // Single requester E holds green indefinitely.
    apply_reset(8'h00, 2);
    release_rst(8'h20, rel);
    for (int k = 1; k <= 3; k++) expect_at(rel + k, K_OUTS, ALL_STOP, "single_clear");
    for (int k = 4; k <= 304; k += 10) expect_at(rel + k, K_OUTS, GO_E, "single_hold_e");
    expect_at(rel + 304, K_TIMER, 12'hFF, "single_timer_sat");
    step(306);

    // Max-out rotation between N and E.
    apply_reset(8'h00, 2);
    release_rst(8'h60, rel);
    expect_at(rel + 4,  K_OUTS, GO_N, "maxout_n_start");
    expect_at(rel + 67, K_OUTS, GO_N, "maxout_n_last");
    for (int k = 68; k <= 71; k++) expect_at(rel + k, K_OUTS, ALL_STOP, "maxout_clear1");
    expect_at(rel + 68, K_STATE, 12'd2, "maxout_state_clear");
    expect_at(rel + 72,  K_OUTS, GO_E, "maxout_e_start");
    expect_at(rel + 135, K_OUTS, GO_E, "maxout_e_last");
    for (int k = 136; k <= 139; k++) expect_at(rel + k, K_OUTS, ALL_STOP, "maxout_clear2");
    expect_at(rel + 140, K_OUTS, GO_N, "maxout_n_again");
    step(142);

    // Gap-out, then IDLE, then a fresh S request.
    apply_reset(8'h00, 2);
    release_rst(8'h40, rel);
    expect_at(rel + 4,  K_OUTS, GO_N, "gap_n_start");
    expect_at(rel + 19, K_OUTS, GO_N, "gap_n_min_hold");
    expect_at(rel + 20, K_OUTS, ALL_STOP, "gap_n_end");
    expect_at(rel + 20, K_STATE, 12'd2, "gap_state_clear");
    expect_at(rel + 20, K_TIMER, 12'd0, "gap_timer_zero");
    step(8);
    sensor = 8'h00;
    expect_at(rel + 24, K_OUTS, ALL_STOP, "gap_idle_outs");
    expect_at(rel + 24, K_STATE, 12'd0, "gap_idle_state");
    expect_at(rel + 24, K_LAST, 12'd0, "gap_idle_last");
    step(17);
    sensor = 8'h10;
    expect_at(rel + 26, K_OUTS, ALL_STOP, "idle_latency");
    expect_at(rel + 27, K_OUTS, GO_S, "idle_grant_s");
    expect_at(rel + 27, K_STATE, 12'd1, "idle_state_green");
    step(4);

    // Reset in the middle of a W grant.
    apply_reset(8'h00, 2);
    release_rst(8'h80, rel);
    expect_at(rel + 4,  K_OUTS, GO_W, "midrst_w_start");
    expect_at(rel + 10, K_OUTS, GO_W, "midrst_w_hold");
    step(10);
    apply_reset(8'hF0, 1);
    release_rst(8'hF0, rel);
    for (int k = 1; k <= 3; k++) expect_at(rel + k, K_OUTS, ALL_STOP, "midrst_clear");
    expect_at(rel + 4, K_OUTS, GO_N, "midrst_next_n");
    expect_at(rel + 4, K_LAST, 12'd0, "midrst_last_n");
    step(6);

    // Random sensors with invariant checking in the monitor.
    apply_reset(8'h00, 2);
    release_rst(8'h00, rel);
    inv_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      sensor = 8'($urandom_range(0, 255));
      gen = 30'($urandom);
      step(1);
    end
    inv_en = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      drain_fail = 1'b1;
      step(2);
    end
    step(1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/light_arbiter.md
Name: light_arbiter

Overview:
- Demand-driven traffic-light controller for one four-way intersection in the VerilogTown simulator; a drop-in alternative to fixed-rotation light modules.
- Samples the intersection's 8 light sensors and grants Go to one approach at a time, round-robin.
- Enforces minimum green, maximum green (only when another approach is waiting) and an all-Stop clearance interval between grants.
- Exactly one direction is ever non-Stop; the output encoding is the simulator's standard 3-bit light code.

Parameters:
- MIN_GREEN, 16: cycles a grant is held before it may gap out (1..MAX_GREEN).
- MAX_GREEN, 64: cycles after which a grant is pre-empted if another approach is requesting (MIN_GREEN..255).
- CLEAR_CYCLES, 4: all-Stop cycles between grants (1..255).

Ports:
- clk, input, 1: simulator clock, rising edge.
- rst, input, 1: reset, synchronous, active-low.
- sensor_light, input, 8: per-light car-present sensors, 1 = car present. Request mapping:
  - N = bit 6
  - S = bit 4
  - E = bit 5
  - W = bit 7
  - Other bits are ignored.
- general_sensors, input, 30: reserved; ignored.
- outN, output, 3: light for northbound cars.
- outS, output, 3: light for southbound cars.
- outE, output, 3: light for eastbound cars.
- outW, output, 3: light for westbound cars.
- debug_port, output, 30: status bits.
  - [7:0] = timer
  - [9:8] = current/last direction
  - [11:10] = state
  - [15:12] = req_q {W,S,E,N}
  - [29:16] = 0

Behaviour:
- Light codes:
  - Stop = 000
  - Forward_only = 001
  - Left_only = 010
  - Right_only = 011
  - Go = 100
  - This block drives only Stop and Go.
- Direction codes: N = 0, E = 1, S = 2, W = 3. Round-robin order is N -> E -> S -> W -> N.
- State codes: IDLE = 0, GREEN = 1, CLEAR = 2.
- All outputs are registered.
- Requests: req_q[3:0] = {W,S,E,N} sensor bits, registered every cycle, so there is one cycle of input latency.
- Reset (rst == 0 at a rising edge):
  - all outputs = Stop
  - state = CLEAR, timer = 0
  - last = W, so N has first priority
  - req_q = 0
  - Reset overrides everything, including mid-grant and mid-clear.
- CLEAR:
  - All outputs are Stop.
  - If timer == CLEAR_CYCLES-1: pick the first set bit of req_q searching from last+1 in round-robin order.
    - If one is found: drive that direction Go, set last = that direction, timer = 0, state = GREEN.
    - If none is found: state = IDLE.
  - Otherwise: timer += 1.
- IDLE:
  - All outputs are Stop.
  - When req_q != 0, the same pick and grant as CLEAR happens on that edge.
- GREEN:
  - Timer increments and saturates at 255.
  - The grant ends on the edge where either condition holds:
    - (a) timer >= MIN_GREEN-1 and req_q[last] == 0 (gap-out);
    - (b) timer >= MAX_GREEN-1 and (req_q & ~onehot(last)) != 0 (max-out).
  - On exit: the granted output goes to Stop, timer = 0, state = CLEAR.
  - With no competing request, the grant holds indefinitely while its own sensor stays 1.
- Simultaneous requests are resolved only by round-robin from last. There is no fixed priority beyond the reset value of last.
- Invariant: at most one output is Go. During CLEAR and IDLE all outputs are Stop.

Decomposition:
- Shared package (light_pkg):
  - light codes (Stop..Go)
  - direction codes (N/E/S/W)
  - state codes
  - sensor bit indices (N = 6, S = 4, E = 5, W = 7)
- Sub-module rr_pick4: combinational. Takes req[3:0] and last[1:0]; returns found and next[1:0] (the first set bit after last, wrapping).
- The remainder (FSM, timer, output registers, debug packing) lives in light_arbiter.

Test Plan:
- Reset: hold rst = 0 for 2 edges, sensors = 8'hFF.
  - Expect all outputs = 000 and debug_port[11:10] = 2.
  - No output is Go until 4 edges after rst rises.
- Single requester: sensor_light = 8'h20 held from rst release.
  - Expect outE = 100 after edge 4; other outputs 000.
  - outE remains 100 for 300 cycles.
- Max-out rotation: sensor_light = 8'h60 (N and E) held from rst release.
  - outN = 100 at edge 4, then Stop at edge 68.
  - All Stop during edges 68-71.
  - outE = 100 at edge 72, then Stop at edge 136.
  - outN = 100 at edge 140.
- Gap-out: sensor_light = 8'h40 from rst release, cleared at edge 8.
  - outN = 100 from edge 4 until Stop at edge 20.
  - After edge 24 the block is in IDLE (debug state 0) with all outputs Stop.
  - Setting 8'h10 then gives outS = 100 two edges later.
- Reset mid-grant: during outW = 100, assert rst = 0 for one edge.
  - All outputs are Stop on that edge.
  - Timer = 0 and state = CLEAR.
  - With 8'hF0 held, the next grant is N (last reset to W).
- Invariant check: random sensors for 10k cycles.
  - At most one output is 100 at any time.
  - Every grant is separated from the next by exactly 4 all-Stop edges.
